data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Sequencer between the MGT2_8R core load/store path and single_port_sync_ram.
//  Accepts one valid/ready request at a time and drives the RAM's active-low
//  n_cs/n_oe/n_rw strobes, address and tri-state data bus with registered, glitch-free timing.
//  Returns read data or a write ack on a one-cycle rsp_valid pulse.
//  Inserts bus-turnaround idle cycles after a read.
// PARAMETERS
//  ADDR_W    8  RAM address width
//  DATA_W    8  RAM data width
//  TURN_CYC  1  idle cycles after a read before any new access; 0 = none
// PORTS
//  clk        in     1       system clock, rising edge
//  rst        in     1       asynchronous reset, active-high
//  req_valid  in     1       request present; held with fields stable until accepted
//  req_ready  out    1       controller can accept a request (IDLE only)
//  req_we     in     1       1 = write, 0 = read
//  req_addr   in     ADDR_W  target address
//  req_wdata  in     DATA_W  write data
//  rsp_valid  out    1       one-cycle pulse: access complete
//  rsp_rdata  out    DATA_W  read data; holds last read value otherwise
//  n_mem_cs   out    1       RAM chip select, active-low
//  n_mem_oe   out    1       RAM output enable, active-low
//  n_mem_rw   out    1       RAM 1 = read, 0 = write
//  mem_addr   out    ADDR_W  RAM address
//  mem_data   inout  DATA_W  RAM data; driven only in WR, else high-Z
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; n_mem_cs=n_mem_oe=n_mem_rw=1; mem_addr=0;
//   mem_data high-Z; rsp_valid=0; rsp_rdata=0; TURN counter=0. In-flight access is dropped, no rsp.
//  All strobes, mem_addr, the data-drive enable and rsp_* are registered (no comb path from req_*).
//  FSM: IDLE, WR, RD_ADDR, RD_CAP, TURN.
//  IDLE: req_ready=1, strobes inactive. Accept on req_valid&req_ready at edge E0.
//   Latch addr/wdata/we. Next state is WR or RD_ADDR.
//  WR (one cycle after E0): cs=0, rw=0, oe=1, mem_data=wdata.
//   RAM writes at E1. After E1: rsp_valid=1 for one cycle, state IDLE.
//   Write latency: 2 cycles accept-to-rsp; throughput: one write per 2 cycles.
//  RD_ADDR (after E0): cs=0, rw=1, oe=0. RAM latches addr at E1 and drives data.
//  RD_CAP (after E1): strobes held. mem_data sampled into rsp_rdata at E2.
//   After E2: rsp_valid=1 for one cycle; state TURN (TURN_CYC>0) or IDLE.
//  TURN: strobes inactive, req_ready=0, for exactly TURN_CYC cycles, then IDLE.
//  req_ready=0 in every state except IDLE. Requests are never queued or lost while held.
//  Address 0 and 2^ADDR_W-1 are handled identically; no wrap or increment logic.
//  rsp_rdata is unchanged by writes.
// CONFIGURATION
//  DMC_STATS_EN defined: adds outputs rd_count[15:0] and wr_count[15:0].
//   Each increments on its rsp_valid, saturates at 0xFFFF, resets to 0.
//  DMC_STATS_EN undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Shared package dmc_pkg: FSM state encoding (3-bit localparams), STAT_W=16,
//   strobe inactive constants.
//  Sub-module dmc_sat_counter (STAT_W-bit saturating incrementer, async rst),
//   instanced twice under DMC_STATS_EN.
//  Tri-state: mem_data = drv_en ? wdata_q : {DATA_W{1'bz}}.
// TESTING
//  Bench includes single_port_sync_ram model with bus-contention checker (X on mem_data = fail).
//  1 Write 0x5A to 0x10, then read 0x10
//    -> writes strobe cs=0,rw=0 for 1 cycle; rsp_valid at +2 and +3 cycles; rsp_rdata=0x5A.
//  2 Back-to-back reads 0x00 then 0xFF, req_valid held high, TURN_CYC=1
//    -> second accept exactly 4 cycles after first; rsp_valid pulses 4 cycles apart.
//  3 Read then write, TURN_CYC=2
//    -> mem_data high-Z for >=2 cycles between oe rising and WR drive; no contention flagged.
//  4 Assert rst in RD_CAP
//    -> strobes go 1 and mem_data high-Z same cycle; no rsp_valid; next request is served normally.
//  5 TURN_CYC=0, read-read-read -> one read per 3 cycles; req_ready low only during RD_ADDR/RD_CAP.
//  6 DMC_STATS_EN, 3 writes + 2 reads -> wr_count=3, rd_count=2;
//    preload rd_count 0xFFFE plus 3 reads -> 0xFFFF.

Source files
------------

// File: rtl/dmc_pkg.sv
// Shared definitions for the data_mem_ctrl RAM sequencer: FSM state encoding,
// statistics width and the inactive level of the active-low RAM strobes.
package dmc_pkg;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_WR      = 3'd1;
    localparam logic [2:0] ENC_RD_ADDR = 3'd2;
    localparam logic [2:0] ENC_RD_CAP  = 3'd3;
    localparam logic [2:0] ENC_TURN    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_WR      = ENC_WR,
        ST_RD_ADDR = ENC_RD_ADDR,
        ST_RD_CAP  = ENC_RD_CAP,
        ST_TURN    = ENC_TURN
    } state_t;

    localparam int STAT_W = 16;

    typedef struct packed {
        logic n_cs;
        logic n_oe;
        logic n_rw;
    } strobe_t;

    localparam strobe_t STRB_IDLE  = '{n_cs: 1'b1, n_oe: 1'b1, n_rw: 1'b1};
    localparam strobe_t STRB_WRITE = '{n_cs: 1'b0, n_oe: 1'b1, n_rw: 1'b0};
    localparam strobe_t STRB_READ  = '{n_cs: 1'b0, n_oe: 1'b0, n_rw: 1'b1};

    // Strobe levels the RAM must see while the controller sits in a given state.
    function automatic strobe_t strobes_for(input state_t s);
        case (s)
            ST_WR:                 return STRB_WRITE;
            ST_RD_ADDR, ST_RD_CAP: return STRB_READ;
            default:               return STRB_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/dmc_sat_counter.sv
// Saturating event counter used for the optional read/write statistics.
module dmc_sat_counter
    import dmc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    logic [STAT_W-1:0] cnt_q;
    logic [STAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {STAT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-request sequencer between the core load/store path and a synchronous RAM.
// Define DMC_STATS_EN to add saturating rd_count/wr_count completion counters.
module data_mem_ctrl
    import dmc_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int TURN_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              n_mem_cs,
    output logic              n_mem_oe,
    output logic              n_mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
`ifdef DMC_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count
`endif
);

    localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic [TURN_W-1:0]   turn_q,      turn_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                drv_en_q,    drv_en_d;
    strobe_t             strb_q,      strb_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        turn_d      = turn_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                rdata_d     = mem_data;
                rsp_valid_d = 1'b1;
                turn_d      = '0;
                state_d     = (TURN_CYC > 0) ? ST_TURN : ST_IDLE;
            end
            ST_TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Strobes and bus drive follow the next state so they change cleanly on the clock edge.
        strb_d   = strobes_for(state_d);
        drv_en_d = (state_d == ST_WR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            turn_q      <= '0;
            rsp_valid_q <= 1'b0;
            drv_en_q    <= 1'b0;
            strb_q      <= STRB_IDLE;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            turn_q      <= turn_d;
            rsp_valid_q <= rsp_valid_d;
            drv_en_q    <= drv_en_d;
            strb_q      <= strb_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign n_mem_cs  = strb_q.n_cs;
    assign n_mem_oe  = strb_q.n_oe;
    assign n_mem_rw  = strb_q.n_rw;
    assign mem_addr  = addr_q;
    assign mem_data  = drv_en_q ? wdata_q : {DATA_W{1'bz}};

`ifdef DMC_STATS_EN
    // Counters advance on the same edge that raises rsp_valid for the access.
    dmc_sat_counter u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state_q == ST_RD_CAP),
        .count (rd_count)
    );

    dmc_sat_counter u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state_q == ST_WR),
        .count (wr_count)
    );
`else
    // Without statistics the completion events are not counted.
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: three instances (TURN_CYC = 1, 2, 0),
// each attached to a behavioural synchronous RAM with a bus-contention checker.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;
    int contention = 0;

    logic       req_valid [3];
    logic       req_we    [3];
    logic [7:0] req_addr  [3];
    logic [7:0] req_wdata [3];
    logic       req_ready [3];
    logic       rsp_valid [3];
    logic [7:0] rsp_rdata [3];
    logic       n_cs      [3];
    logic       n_oe      [3];
    logic       n_rw      [3];
    logic [7:0] mem_addr  [3];
    wire  [7:0] md0, md1, md2;
    logic [7:0] ram_in    [3];
    logic       ram_drv   [3];
    logic       ram_hold  [3];
    logic       ram_rdv   [3];
    logic [7:0] ram_q     [3];
    logic [7:0] ram_mem   [3][256];
`ifdef DMC_STATS_EN
    logic [15:0] rd_count [3];
    logic [15:0] wr_count [3];
`endif

    data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .TURN_CYC(1)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .n_mem_cs(n_cs[0]),
        .n_mem_oe(n_oe[0]), .n_mem_rw(n_rw[0]), .mem_addr(mem_addr[0]), .mem_data(md0)
`ifdef DMC_STATS_EN
        , .rd_count(rd_count[0]), .wr_count(wr_count[0])
`endif
    );

    data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .TURN_CYC(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .n_mem_cs(n_cs[1]),
        .n_mem_oe(n_oe[1]), .n_mem_rw(n_rw[1]), .mem_addr(mem_addr[1]), .mem_data(md1)
`ifdef DMC_STATS_EN
        , .rd_count(rd_count[1]), .wr_count(wr_count[1])
`endif
    );

    data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .TURN_CYC(0)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .n_mem_cs(n_cs[2]),
        .n_mem_oe(n_oe[2]), .n_mem_rw(n_rw[2]), .mem_addr(mem_addr[2]), .mem_data(md2)
`ifdef DMC_STATS_EN
        , .rd_count(rd_count[2]), .wr_count(wr_count[2])
`endif
    );

    // RAM output: drives after a read edge for as long as output enable stays low.
    for (genvar g = 0; g < 3; g++) begin : g_drv
        assign ram_drv[g] = ram_rdv[g] && !n_oe[g];
    end
    assign md0 = ram_drv[0] ? ram_q[0] : 8'bz;
    assign md1 = ram_drv[1] ? ram_q[1] : 8'bz;
    assign md2 = ram_drv[2] ? ram_q[2] : 8'bz;
    assign ram_in[0] = md0;
    assign ram_in[1] = md1;
    assign ram_in[2] = md2;

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!n_cs[g] && !n_rw[g]) ram_mem[g][mem_addr[g]] <= ram_in[g];
            if (!n_cs[g] && n_rw[g])  ram_q[g] <= ram_mem[g][mem_addr[g]];
            ram_rdv[g]  <= !n_cs[g] && n_rw[g];
            ram_hold[g] <= ram_drv[g];
        end
    end

    // Controller write drive while the RAM drives or is still releasing the bus.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!n_cs[g] && !n_rw[g] && (ram_drv[g] || ram_hold[g])) begin
                contention++;
                $display("[TB] FAIL bus_contention inst%0d: controller drives while RAM busy", g);
            end
        end
    end

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        int         exp_lat;
        logic [2:0] exp_strb;
        int         exp_cs;
    } vec_t;

    vec_t vecs [8];

    logic       seq_we    [4];
    logic [7:0] seq_addr  [4];
    logic [7:0] seq_wdata [4];
    int         acc_t     [4];
    int         rsp_t     [4];
    logic [7:0] rsp_d     [4];
    logic       ready_log [64];
    logic       oe_log    [64];
    logic       wr_log    [64];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int g, input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
        req_valid[g] = v;
        req_we[g]    = we;
        req_addr[g]  = a;
        req_wdata[g] = d;
    endtask

    // One complete access: wait for ready, accept, then follow it to its response.
    task automatic applyStimulus(input int g, input string tag, input vec_t v);
        int wait_cyc = 0;
        int lat      = 1;
        int cs_cyc   = 0;
        @(negedge clk);
        drive(g, 1'b1, v.we, v.addr, v.wdata);
        while (!req_ready[g] && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!req_ready[g]) begin
            checkOutput({tag, "_accept_timeout"}, 0, 1);
            drive(g, 1'b0, 1'b0, 8'h00, 8'h00);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        drive(g, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput({tag, "_strobes"}, {n_cs[g], n_oe[g], n_rw[g]}, v.exp_strb);
        checkOutput({tag, "_mem_addr"}, mem_addr[g], v.addr);
        while (!rsp_valid[g] && lat < 20) begin
            if (!n_cs[g]) cs_cyc++;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, v.exp_lat);
        checkOutput({tag, "_cs_cycles"}, cs_cyc, v.exp_cs);
        checkOutput({tag, "_rdata"}, rsp_rdata[g], v.exp_rdata);
        checkOutput({tag, "_strobes_idle"}, {n_cs[g], n_oe[g], n_rw[g]}, 3'b111);
        if (v.we) checkOutput({tag, "_ram_content"}, ram_mem[g][v.addr], v.wdata);
    endtask

    // Holds req_valid high across n requests and logs accept/response timing per cycle.
    task automatic runSeq(input int g, input int n);
        int k = 0;
        int r = 0;
        int t = 0;
        @(negedge clk);
        while (r < n && t < 60) begin
            if (k < n) drive(g, 1'b1, seq_we[k], seq_addr[k], seq_wdata[k]);
            else       drive(g, 1'b0, 1'b0, 8'h00, 8'h00);
            ready_log[t] = req_ready[g];
            oe_log[t]    = n_oe[g];
            wr_log[t]    = !n_cs[g] && !n_rw[g];
            if (rsp_valid[g]) begin
                rsp_t[r] = t;
                rsp_d[r] = rsp_rdata[g];
                r++;
            end
            if (k < n && req_ready[g]) begin
                acc_t[k] = t;
                k++;
            end
            @(negedge clk);
            t++;
        end
        drive(g, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("seq_responses", r, n);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int last_oe;
        int first_wr;
        int bad_ready;
        vec_t v;

        //             we    addr   wdata  rdata  lat strb    cs
        vecs[0] = '{1'b1, 8'h10, 8'h5A, 8'h00, 2, 3'b010, 1};
        vecs[1] = '{1'b0, 8'h10, 8'h00, 8'h5A, 3, 3'b001, 2};
        vecs[2] = '{1'b1, 8'h00, 8'h11, 8'h5A, 2, 3'b010, 1};
        vecs[3] = '{1'b1, 8'hFF, 8'hEE, 8'h5A, 2, 3'b010, 1};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h11, 3, 3'b001, 2};
        vecs[5] = '{1'b0, 8'hFF, 8'h00, 8'hEE, 3, 3'b001, 2};
        vecs[6] = '{1'b1, 8'h10, 8'h33, 8'hEE, 2, 3'b010, 1};
        vecs[7] = '{1'b0, 8'h10, 8'h00, 8'h33, 3, 3'b001, 2};

        rst = 1'b1;
        for (int g = 0; g < 3; g++) drive(g, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("reset_strobes_%0d", g), {n_cs[g], n_oe[g], n_rw[g]}, 3'b111);
            checkOutput($sformatf("reset_mem_addr_%0d", g), mem_addr[g], 8'h00);
            checkOutput($sformatf("reset_rsp_%0d", g), {rsp_valid[g], rsp_rdata[g]}, 9'h000);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("ready_after_reset_%0d", g), req_ready[g], 1'b1);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, $sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back reads at both address extremes with valid held, one turnaround cycle.
        seq_we[0] = 1'b0; seq_addr[0] = 8'h00; seq_wdata[0] = 8'h00;
        seq_we[1] = 1'b0; seq_addr[1] = 8'hFF; seq_wdata[1] = 8'h00;
        runSeq(0, 2);
        checkOutput("t2_accept_spacing", acc_t[1] - acc_t[0], 4);
        checkOutput("t2_rsp_spacing", rsp_t[1] - rsp_t[0], 4);
        checkOutput("t2_read_latency", rsp_t[0] - acc_t[0], 3);
        checkOutput("t2_rdata0", rsp_d[0], 8'h11);
        checkOutput("t2_rdata1", rsp_d[1], 8'hEE);

        // Read followed by write with two turnaround cycles.
        v = '{1'b1, 8'h20, 8'h77, 8'h00, 2, 3'b010, 1};
        applyStimulus(1, "t3_prewrite", v);
        seq_we[0] = 1'b0; seq_addr[0] = 8'h20; seq_wdata[0] = 8'h00;
        seq_we[1] = 1'b1; seq_addr[1] = 8'h21; seq_wdata[1] = 8'h99;
        runSeq(1, 2);
        checkOutput("t3_accept_spacing", acc_t[1] - acc_t[0], 5);
        checkOutput("t3_rdata", rsp_d[0], 8'h77);
        last_oe  = -1;
        first_wr = -1;
        for (int t = 0; t < rsp_t[1]; t++) begin
            if (!oe_log[t]) last_oe = t;
            if (wr_log[t] && first_wr < 0 && last_oe >= 0) first_wr = t;
        end
        checkOutput("t3_highz_gap_ge2", (first_wr - last_oe - 1) >= 2, 1'b1);
        checkOutput("t3_ram_content", ram_mem[1][8'h21], 8'h99);

        // No turnaround: three reads, one every three cycles.
        v = '{1'b1, 8'h30, 8'hA5, 8'h00, 2, 3'b010, 1};
        applyStimulus(2, "t5_prewrite", v);
        for (int k = 0; k < 3; k++) begin
            seq_we[k] = 1'b0; seq_addr[k] = 8'h30; seq_wdata[k] = 8'h00;
        end
        runSeq(2, 3);
        checkOutput("t5_spacing_01", acc_t[1] - acc_t[0], 3);
        checkOutput("t5_spacing_12", acc_t[2] - acc_t[1], 3);
        checkOutput("t5_rdata", {rsp_d[0], rsp_d[1], rsp_d[2]}, 24'hA5A5A5);
        bad_ready = 0;
        for (int t = acc_t[0]; t <= acc_t[2]; t++) begin
            if (ready_log[t] != (((t - acc_t[0]) % 3) == 0)) bad_ready++;
        end
        checkOutput("t5_ready_pattern_errors", bad_ready, 0);

        // Reset while the read capture cycle is in progress.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        for (int w = 0; w < 10 && !req_ready[0]; w++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("t4_in_rd_cap", {n_cs[0], n_oe[0], n_rw[0]}, 3'b001);
        rst = 1'b1;
        #1;
        checkOutput("t4_reset_strobes", {n_cs[0], n_oe[0], n_rw[0]}, 3'b111);
        checkOutput("t4_reset_rsp", {rsp_valid[0], rsp_rdata[0]}, 9'h000);
        checkOutput("t4_reset_ready", req_ready[0], 1'b1);
        @(negedge clk);
        rst = 1'b0;
        bad_ready = 0;
        for (int t = 0; t < 4; t++) begin
            if (rsp_valid[0]) bad_ready++;
            @(negedge clk);
        end
        checkOutput("t4_no_rsp_after_reset", bad_ready, 0);
        applyStimulus(0, "t4_recover", vecs[7]);

        checkOutput("no_contention", contention, 0);

`ifdef DMC_STATS_EN
        for (int i = 0; i < 3; i++) begin
            v = '{1'b1, 8'(8'h40 + i), 8'(8'hC0 + i), 8'h33, 2, 3'b010, 1};
            applyStimulus(0, $sformatf("stat_wr%0d", i), v);
        end
        applyStimulus(0, "stat_rd", vecs[7]);
        checkOutput("stat_wr_count", wr_count[0], 16'd3);
        checkOutput("stat_rd_count", rd_count[0], 16'd2);
        @(negedge clk);
        force dut0.u_rd_cnt.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut0.u_rd_cnt.cnt_q;
        for (int i = 0; i < 3; i++) applyStimulus(0, $sformatf("stat_sat%0d", i), vecs[7]);
        checkOutput("stat_rd_saturated", rd_count[0], 16'hFFFF);
        checkOutput("stat_wr_unchanged", wr_count[0], 16'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
